// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: requester ids, read-return tags
// and the default BRAM read latency.
package dmem_pkg;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } rd_tag_t;

  localparam int DMEM_RD_LAT = 2;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Fixed-latency shift pipeline of read tags; the tag leaving the last stage
// says which requester the current mem_rdata belongs to.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1 + DMEM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t in_tag,
  output logic    m0_rvalid,
  output logic    m1_rvalid
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      rd_tag_t tag_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) tag_reg <= '0;
          else     tag_reg <= in_tag;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) tag_reg <= '0;
          else     tag_reg <= g_stage[gi-1].tag_reg;
        end
      end
    end
  endgenerate

  rd_tag_t out_tag;
  assign out_tag = g_stage[DEPTH-1].tag_reg;

  // Returns are suppressed during reset so a stale tail tag cannot leak out.
  assign m0_rvalid = !rst && out_tag.v && (out_tag.id == REQ_CORE);
  assign m1_rvalid = !rst && out_tag.v && (out_tag.id == REQ_HOST);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data BRAM between the core (M0)
// and the host/loader (M1); read data is routed back by an in-order tag pipe.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = DMEM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  req_id_t           ptr_reg, ptr_next;
  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t           rd_tag;

  // A lone requester always wins; on contention the pointer side wins.
  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    ptr_next = ptr_reg;
    if (!rst) begin
      if (m0_req && (!m1_req || ptr_reg == REQ_CORE)) m0_gnt = 1'b1;
      else if (m1_req)                                  m1_gnt = 1'b1;
    end
    if (m0_gnt)      ptr_next = REQ_HOST;
    else if (m1_gnt) ptr_next = REQ_CORE;
  end

  always_comb begin
    gnt_any   = m0_gnt | m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    rd_tag.v  = gnt_any && !sel_we;
    rd_tag.id = m1_gnt ? REQ_HOST : REQ_CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= REQ_CORE;
      mem_wea   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ptr_reg <= ptr_next;
      mem_wea <= gnt_any && sel_we;
      if (gnt_any) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH(1 + RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_tag   (rd_tag),
    .m0_rvalid(m0_rvalid),
    .m1_rvalid(m1_rvalid)
  );

  // BRAM returns one word per cycle; only the port with rvalid consumes it.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule
